// File: rtl/mux_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
// Owner encoding, state encoding and a one-hot helper are used by all arbiter files.
package mux_arbiter8_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    onehot8 = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux_arbiter8_if.sv
// Request/grant bundle between the requesters and the mux select arbiter.
// The master side drives req; the slave (arbiter) side drives grant and select.
interface mux_arbiter8_if;
  import mux_arbiter8_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             tout;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  sel_valid,
    input  tout
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output sel_valid,
    output tout
  );

endinterface

// File: rtl/mux_arbiter8_rr_pick8.sv
// Combinational round-robin pick: rotate req so ptr is bit 0, priority-encode
// the lowest set bit, then add ptr back to get the absolute requester index.
module rr_pick8
  import mux_arbiter8_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;

  // rot[i] is the requester i positions after ptr, wrapping modulo 8
  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Scan from the top down so the lowest set bit wins
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/mux_arbiter8.sv
// Round-robin arbiter owning the shared 8:1 mux select, with hold-while-requesting
// and an optional forced release after TIMEOUT cycles when others are waiting.
module mux_arbiter8
  import mux_arbiter8_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arbiter8_if.slave bus
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             sel_valid_q;
  logic             tout_q;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             others_pending;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req      = bus.req[sel_q];
  assign others_pending = |(bus.req & ~onehot8(sel_q));

  // An owner dropping its request takes precedence over a coincident timeout,
  // and cnt stops at its maximum so a long uncontested grant never re-times-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q       <= onehot8(pick_idx);
            sel_q       <= pick_idx;
            sel_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (!owner_req) begin
            gnt_q       <= '0;
            sel_valid_q <= 1'b0;
            ptr         <= sel_q + 1'b1;
            state       <= IDLE;
          end else if (TO_EN && (cnt == TO_LAST) && others_pending) begin
            gnt_q       <= '0;
            sel_valid_q <= 1'b0;
            ptr         <= sel_q + 1'b1;
            tout_q      <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.tout      = tout_q;

endmodule
